// File: rtl/leg_uop_pkg.sv
// Shared definitions for the uop fetch path: HALT encoding, fetch states and store defaults.
package leg_uop_pkg;

    localparam logic [7:0]  HALT_OPCODE             = 8'hFF;
    localparam int unsigned UOP_BUF_SIZE_DEFAULT    = 128;
    localparam int unsigned UOP_BUF_WIDTH_DEFAULT   = 64;

    typedef enum logic [0:0] {
        StFetch  = 1'b0,
        StHalted = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/uop_fifo.sv
// Small synchronous FIFO; the head output is read from registered storage only.
module uop_fifo
    import leg_uop_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [PW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (PW+1)'(DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_head  = o_empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PW'(1);
            if (w_pop)  r_rd <= r_rd + PW'(1);
            if (w_push && !w_pop) r_cnt <= r_cnt + (PW+1)'(1);
            else if (w_pop && !w_push) r_cnt <= r_cnt - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !reset && !i_flush) r_mem[r_wr] <= i_push_data;
    end

endmodule

// File: rtl/uop_fetch_unit.sv
// Fetches uops sequentially from the uop store into a small FIFO, stopping on HALT
// and restarting on consumer redirect.
module uop_fetch_unit
    import leg_uop_pkg::*;
#(
    parameter int unsigned UOP_BUF_SIZE  = UOP_BUF_SIZE_DEFAULT,
    parameter int unsigned UOP_BUF_WIDTH = UOP_BUF_WIDTH_DEFAULT,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    output logic [$clog2(UOP_BUF_SIZE)-1:0] uop_addr,
    input  logic [UOP_BUF_WIDTH-1:0]        uop,
    input  logic                            redirect_valid,
    input  logic [$clog2(UOP_BUF_SIZE)-1:0] redirect_addr,
    output logic                            out_valid,
    output logic [UOP_BUF_WIDTH-1:0]        out_uop,
    output logic [$clog2(UOP_BUF_SIZE)-1:0] out_addr,
    input  logic                            out_ready,
    output logic                            halted
);

    localparam int unsigned AW = $clog2(UOP_BUF_SIZE);
    localparam int unsigned DW = UOP_BUF_WIDTH + AW;

    fetch_state_e  r_state;
    logic [AW-1:0] r_pc;
    logic          w_full;
    logic          w_empty;
    logic          w_deq;
    logic          w_enq;
    logic          w_is_halt;
    logic [DW-1:0] w_head;

    assign w_deq     = ~w_empty & out_ready;
    assign w_enq     = (r_state == StFetch) & (~w_full | w_deq) & ~redirect_valid;
    assign w_is_halt = (uop[UOP_BUF_WIDTH-1 -: 8] == HALT_OPCODE);

    assign uop_addr  = r_pc;
    assign out_valid = ~w_empty;
    assign out_uop   = w_head[DW-1:AW];
    assign out_addr  = w_head[AW-1:0];
    assign halted    = (r_state == StHalted);

    // PC wraps naturally since the store size is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= '0;
            r_state <= StFetch;
        end else if (redirect_valid) begin
            r_pc    <= redirect_addr;
            r_state <= StFetch;
        end else if (w_enq) begin
            if (w_is_halt) begin
                r_state <= StHalted;
            end else begin
                r_pc <= r_pc + AW'(1);
            end
        end
    end

    uop_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_uop_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_enq),
        .i_push_data ({uop, r_pc}),
        .i_pop       (w_deq),
        .i_flush     (redirect_valid),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (w_head)
    );

endmodule

// File: tb/tb_uop_fetch_unit.sv
// Directed bench for uop_fetch_unit with a behavioural uop store (uop[i] = i).
module tb_uop_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  uop_addr;
    logic [63:0] uop;
    logic        redirect_valid;
    logic [6:0]  redirect_addr;
    logic        out_valid;
    logic [63:0] out_uop;
    logic [6:0]  out_addr;
    logic        out_ready;
    logic        halted;

    logic [63:0] store [128];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    assign uop = store[uop_addr];

    uop_fetch_unit u_dut (
        .clk            (clk),
        .reset          (reset),
        .uop_addr       (uop_addr),
        .uop            (uop),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .out_valid      (out_valid),
        .out_uop        (out_uop),
        .out_addr       (out_addr),
        .out_ready      (out_ready),
        .halted         (halted)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        reset     = 1'b1;
        out_ready = 1'b0;
        tick();
        reset     = 1'b0;
        out_ready = ready;
    endtask

    initial begin
        bit found;
        int e;
        for (int i = 0; i < 128; i++) store[i] = 64'(i);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        out_ready      = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_uop", out_uop, 64'd0);
        check("rst_addr", 64'(out_addr), 64'd0);
        check("rst_pc", 64'(uop_addr), 64'd0);

        // Streaming, one uop per cycle from cycle 1
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_addr", 64'(out_addr), 64'(i));
            check("stream_uop", out_uop, 64'(i));
        end

        // Backpressure: fill to depth, hold, then drain contiguously
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("bp_pc_frozen", 64'(uop_addr), 64'd4);
        check("bp_head_addr", 64'(out_addr), 64'd0);
        check("bp_head_uop", out_uop, 64'd0);
        out_ready = 1'b1;
        e = 0;
        for (int i = 0; i < 10; i++) begin
            check("bp_drain_addr", 64'(out_addr), 64'(e));
            check("bp_drain_valid", 64'(out_valid), 64'd1);
            tick();
            e++;
        end

        // PC wrap 127 -> 0
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (out_valid && out_addr == 7'd127) found = 1'b1;
            else tick();
        end
        check("wrap_reached_127", 64'(found), 64'd1);
        tick();
        check("wrap_addr0", 64'(out_addr), 64'd0);
        check("wrap_uop0", out_uop, 64'd0);

        // HALT at address 5, then redirect to 20
        store[5] = {8'hFF, 56'd5};
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("halt_seq_addr", 64'(out_addr), 64'(i));
        end
        check("halt_flag", 64'(halted), 64'd1);
        check("halt_pc_hold", 64'(uop_addr), 64'd5);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_no_more", 64'(out_valid), 64'd0);
        end
        redirect_valid = 1'b1;
        redirect_addr  = 7'd20;
        tick();
        redirect_valid = 1'b0;
        check("redir_flush", 64'(out_valid), 64'd0);
        check("redir_unhalt", 64'(halted), 64'd0);
        check("redir_pc", 64'(uop_addr), 64'd20);
        tick();
        check("redir_first_addr", 64'(out_addr), 64'd20);
        check("redir_first_uop", out_uop, 64'd20);
        store[5] = 64'd5;

        // Redirect while full with out_ready=1
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 7'd40;
        tick();
        redirect_valid = 1'b0;
        check("full_redir_empty", 64'(out_valid), 64'd0);
        check("full_redir_pc", 64'(uop_addr), 64'd40);
        tick();
        check("full_redir_addr40", 64'(out_addr), 64'd40);
        tick();
        check("full_redir_addr41", 64'(out_addr), 64'd41);

        // Reset with 3 entries queued, overriding a redirect
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 7'd60;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("pre_rst_head", 64'(out_addr), 64'd60);
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 7'd99;
        tick();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_pc", 64'(uop_addr), 64'd0);
        check("mid_rst_addr", 64'(out_addr), 64'd0);
        out_ready = 1'b1;
        tick();
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_addr", 64'(out_addr), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uop_fetch_unit.md
UOP_FETCH_UNIT -- requirements
Module: uop_fetch_unit

Interface
REQ-001 SHALL have parameter UOP_BUF_SIZE, default 128, number of uop store entries (power of 2).
REQ-002 SHALL have parameter UOP_BUF_WIDTH, default 64, uop width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, uop FIFO entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port uop_addr  output  $clog2(UOP_BUF_SIZE)  uop store read address (fetch PC).
REQ-007 SHALL have port uop  input  UOP_BUF_WIDTH  store read data, combinational function of uop_addr in the same cycle.
REQ-008 SHALL have port redirect_valid  input  1  consumer requests fetch restart.
REQ-009 SHALL have port redirect_addr  input  $clog2(UOP_BUF_SIZE)  restart address.
REQ-010 SHALL have port out_valid  output  1  out_uop/out_addr hold a valid uop.
REQ-011 SHALL have port out_uop  output  UOP_BUF_WIDTH  head-of-FIFO uop.
REQ-012 SHALL have port out_addr  output  $clog2(UOP_BUF_SIZE)  store address of out_uop.
REQ-013 SHALL have port out_ready  input  1  consumer accepts head when out_valid & out_ready.
REQ-014 SHALL have port halted  output  1  fetch stopped on HALT uop.

Function
REQ-015 SHALL implement states FETCH and HALTED; reset enters FETCH.
REQ-016 In FETCH, SHALL enqueue {uop, uop_addr} and increment PC each cycle the FIFO can accept (not full, or full with dequeue same cycle).
REQ-017 PC SHALL wrap from UOP_BUF_SIZE-1 to 0.
REQ-018 FIFO full with no dequeue: SHALL hold PC and not enqueue; no uop lost or duplicated.
REQ-019 On enqueue of a uop with uop[UOP_BUF_WIDTH-1 -: 8] == HALT_OPCODE, SHALL enqueue it, hold PC, enter HALTED next cycle.
REQ-020 In HALTED, SHALL not enqueue; halted=1; FIFO continues draining.
REQ-021 redirect_valid SHALL take priority over enqueue, dequeue and state: next cycle FIFO empty, PC=redirect_addr, state FETCH, halted=0.
REQ-022 Redirect cycle: out_valid & out_ready handshake that cycle SHALL still count as consumed by the consumer; no entry survives the flush.
REQ-023 out_valid SHALL equal FIFO non-empty; out_uop/out_addr SHALL be registered FIFO head, no combinational path from uop to out_uop.
REQ-024 Minimum latency: uop at uop_addr enqueued at edge N SHALL appear on out_* in cycle N+1.
REQ-025 out_uop/out_addr SHALL remain stable while out_valid & !out_ready.
REQ-026 Simultaneous enqueue and dequeue SHALL keep occupancy constant, including when full or empty-with-one-entry.
REQ-027 Sustained out_ready=1 SHALL yield one uop per cycle throughput.

Reset
REQ-028 Reset SHALL set PC=0, FIFO empty, state FETCH, out_valid=0, halted=0, out_uop=0, out_addr=0; uop_addr=0 in the first cycle after reset.
REQ-029 Reset asserted mid-operation SHALL discard all FIFO contents and override redirect_valid.

Structure
REQ-030 SHALL place HALT_OPCODE (8'hFF), the fetch state enum and default UOP_BUF_SIZE/UOP_BUF_WIDTH in shared package leg_uop_pkg.
REQ-031 SHALL instantiate one sub-module uop_fifo (parameterized width/depth, push/pop/flush, full/empty, registered head).
REQ-032 SHALL connect to microcode_unit via the uop_addr/uop store interface upstream and out_* downstream; no other external ports.

Verification
REQ-033 Store uop[i]=i, out_ready=1 after reset -> out_addr 0,1,2,... one per cycle from cycle 1, out_uop==out_addr.
REQ-034 out_ready=0 for 10 cycles -> exactly FIFO_DEPTH(4) entries, uop_addr frozen at 4; release -> addrs 0..N contiguous, no gap/duplicate.
REQ-035 Run to addr 127, out_ready=1 -> out_addr 127 followed by 0.
REQ-036 HALT uop at addr 5 -> addrs 0..5 delivered, halted=1, no addr 6; redirect_addr=20 -> next out_addr 20, halted=0.
REQ-037 Redirect to 40 while FIFO full with out_ready=1 -> no pre-redirect entries after redirect; first out_addr 40 two cycles after redirect.
REQ-038 Reset pulse with FIFO holding 3 entries -> out_valid=0 next cycle, then out_addr 0.
